// File: rtl/obi_ram_pkg.sv
// obi_ram_pkg: shared OBI widths, error-data constant and request/response bundles
package obi_ram_pkg;
  localparam int OBI_DW = 32;
  localparam int OBI_AW = 32;
  localparam logic [OBI_DW-1:0] DEADBEEF = 32'hDEAD_BEEF;
  typedef struct packed {
    logic              req;
    logic [OBI_AW-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [OBI_DW-1:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
    logic              err;
  } obi_rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; priority pointer moves past the winner on advance
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, win, idx;
  // Scan from the pointer upward; descending loop lets the nearest requester win
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_q) + i) % N);
      win = req_i[idx] ? idx : win;
    end
    gnt_o = |req_i ? N'(1) << win : '0;
  end
  always_ff @(posedge clk_i)
    if (rst_i) ptr_q <= '0;
    else if (advance_i && |req_i) ptr_q <= 32'(win) == N - 1 ? '0 : win + 1'b1;
endmodule

// File: rtl/obi_banked_ram.sv
// obi_banked_ram: word-interleaved banked RAM behind NUM_PORTS OBI slave ports,
// per-bank round-robin arbitration, single-cycle registered responses.
module obi_banked_ram
  import obi_ram_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
  parameter int          SRAM_SIZE      = 4096,
  parameter int          NUM_PORTS      = 2,
  parameter int          NUM_BANKS      = 2,
  parameter logic [7:0]  RO_PORT_MASK   = 8'b10
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_PORTS-1:0]              req_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  input  logic [NUM_PORTS-1:0][OBI_AW-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS-1:0][3:0]         be_i,
  input  logic [NUM_PORTS-1:0][OBI_DW-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [NUM_PORTS-1:0][OBI_DW-1:0]  rdata_o,
  output logic [NUM_PORTS-1:0]              err_o,
  output logic                              illegal_memory_o
);
  localparam int LB   = $clog2(NUM_BANKS);
  localparam int BW   = NUM_BANKS > 1 ? LB : 1;
  localparam int ROWS = SRAM_SIZE / (4 * NUM_BANKS);
  localparam int RW   = ROWS > 1 ? $clog2(ROWS) : 1;
  logic [NUM_PORTS-1:0]                 bad;
  logic [NUM_PORTS-1:0][BW-1:0]         bank;
  logic [NUM_PORTS-1:0][RW-1:0]         row;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  breq, bgnt;
  logic [OBI_DW-1:0]                    mem [NUM_BANKS][ROWS];
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    logic [31:0] off, word;
    logic        in_range;
    assign off      = addr_i[p] - SRAM_BASE_ADDR;
    assign word     = off >> 2;
    assign in_range = addr_i[p] >= SRAM_BASE_ADDR && off < 32'(SRAM_SIZE);
    assign bad[p]   = !in_range || (we_i[p] && RO_PORT_MASK[p]);
    assign bank[p]  = BW'(word & 32'(NUM_BANKS - 1));
    assign row[p]   = RW'(word >> LB);
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
      assign breq[b][p] = req_i[p] && !bad[p] && bank[p] == BW'(b);
    end
    rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (breq[b]),
      .advance_i (!rst_i),
      .gnt_o     (bgnt[b])
    );
  end
  // Illegal requests never touch a bank, so they are granted on sight
  always_comb begin
    gnt_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gnt_o[p] = req_i[p] && bad[p];
      for (int b = 0; b < NUM_BANKS; b++) gnt_o[p] = gnt_o[p] || bgnt[b][p];
    end
    gnt_o = rst_i ? '0 : gnt_o;
  end
  always_ff @(posedge clk_i)
    for (int p = 0; p < NUM_PORTS; p++)
      if (gnt_o[p] && !bad[p] && we_i[p])
        for (int k = 0; k < 4; k++)
          if (be_i[p][k]) mem[bank[p]][row[p]][8*k +: 8] <= wdata_i[p][8*k +: 8];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o         <= '0;
      err_o            <= '0;
      rdata_o          <= '0;
      illegal_memory_o <= 1'b0;
    end else begin
      rvalid_o         <= gnt_o;
      err_o            <= gnt_o & bad;
      illegal_memory_o <= |(gnt_o & bad);
      for (int p = 0; p < NUM_PORTS; p++)
        rdata_o[p] <= !gnt_o[p] ? '0 :
                      bad[p]    ? DEADBEEF :
                      we_i[p]   ? '0 : mem[bank[p]][row[p]];
    end
  end
endmodule

// File: tb/tb_obi_banked_ram.sv
// tb_obi_banked_ram: directed OBI scenarios plus random traffic against a word-array reference model
module tb_obi_banked_ram;
  import obi_ram_pkg::*;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WORDS = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = '0, we = '0, gnt, rvalid, err;
  logic [1:0][31:0] addr = '0, wdata = '0, rdata;
  logic [1:0][3:0] be = '0;
  logic ill;
  int n_tests = 0, n_fail = 0;
  logic [31:0] mem_m [WORDS];
  int ptr_m [2];
  logic [1:0] obs_v, obs_e;
  logic [1:0][31:0] obs_d;
  logic obs_ill;
  always #5 clk = ~clk;
  obi_banked_ram dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_i            (req),
    .gnt_o            (gnt),
    .addr_i           (addr),
    .we_i             (we),
    .be_i             (be),
    .wdata_i          (wdata),
    .rvalid_o         (rvalid),
    .rdata_o          (rdata),
    .err_o            (err),
    .illegal_memory_o (ill)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit legal(input int p);
    return addr[p] >= BASE && addr[p] < BASE + 32'd4096 && !(p == 1 && we[p]);
  endfunction
  function automatic int widx(input int p);
    return int'((addr[p] - BASE) >> 2);
  endfunction
  // One clock: predict grants from the current request set, check them, then check the responses
  task automatic step(output logic [1:0] g);
    logic [1:0] ge, ve, ee, lg;
    logic [1:0][31:0] de;
    logic ie, r;
    bit done;
    int p;
    ge = '0; ve = '0; ee = '0; de = '0; lg = '0;
    r = rst;
    for (int q = 0; q < 2; q++) lg[q] = legal(q);
    if (!r) begin
      for (int q = 0; q < 2; q++) if (req[q] && !lg[q]) ge[q] = 1'b1;
      for (int b = 0; b < 2; b++) begin
        done = 0;
        for (int k = 0; k < 2; k++) begin
          p = (ptr_m[b] + k) % 2;
          if (!done && req[p] && lg[p] && widx(p) % 2 == b) begin
            ge[p] = 1'b1;
            done = 1;
            ptr_m[b] = (p + 1) % 2;
          end
        end
      end
    end
    for (int q = 0; q < 2; q++) if (ge[q]) begin
      ve[q] = 1'b1;
      ee[q] = !lg[q];
      de[q] = !lg[q] ? 32'hDEAD_BEEF : we[q] ? 32'h0 : mem_m[widx(q)];
    end
    for (int q = 0; q < 2; q++) if (ge[q] && lg[q] && we[q])
      for (int k = 0; k < 4; k++) if (be[q][k]) mem_m[widx(q)][8*k +: 8] = wdata[q][8*k +: 8];
    ie = |(ge & ~lg);
    #1;
    g = gnt;
    check("gnt", gnt, ge);
    @(posedge clk);
    #1;
    if (r) ptr_m = '{0, 0};
    check("rvalid", rvalid, ve);
    check("err", err, ee);
    check("illegal", ill, ie);
    for (int q = 0; q < 2; q++) if (ve[q] || r) check($sformatf("rdata%0d", q), rdata[q], de[q]);
    obs_v = rvalid; obs_e = err; obs_d = rdata; obs_ill = ill;
    req = req & ~ge;
  endtask
  task automatic xfer(input int p, input logic w, input logic [31:0] a, input logic [3:0] bb, input logic [31:0] d);
    logic [1:0] g;
    int t;
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = bb; wdata[p] = d;
    t = 0;
    do begin
      step(g);
      t++;
    end while (req[p] && t < 10);
    check("xfer_done", {31'b0, req[p]}, 32'h0);
    req[p] = 1'b0;
  endtask
  initial begin
    logic [1:0] g;
    logic [31:0] prior;
    int r;
    ptr_m = '{0, 0};
    @(posedge clk);
    #1;
    step(g);
    step(g);
    rst = 1'b0;
    for (int w = 0; w < 64; w++) xfer(0, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom());
    // write then read back from the other port
    xfer(0, 1'b1, BASE, 4'hF, 32'h1234_5678);
    xfer(1, 1'b0, BASE, 4'h0, 32'h0);
    check("t1_rvalid", {31'b0, obs_v[1]}, 32'h1);
    check("t1_err", {31'b0, obs_e[1]}, 32'h0);
    check("t1_rdata", obs_d[1], 32'h1234_5678);
    // different banks complete in parallel
    req = 2'b11; we = 2'b00; addr[0] = BASE; addr[1] = BASE + 32'h4;
    step(g);
    check("t2_gnt", {30'b0, g}, 32'h3);
    check("t2_rvalid", {30'b0, obs_v}, 32'h3);
    rst = 1'b1;
    step(g);
    rst = 1'b0;
    // same bank contention alternates from a freshly reset pointer
    for (int k = 0; k < 4; k++) begin
      req = 2'b11; we = 2'b00; addr[0] = BASE + 32'h8; addr[1] = BASE + 32'h8;
      step(g);
      check($sformatf("t3_gnt%0d", k), {30'b0, g}, k % 2 == 0 ? 32'h1 : 32'h2);
    end
    req = 2'b00;
    step(g);
    // out-of-range reads on both sides of the window
    xfer(0, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0);
    check("t4_lo_rdata", obs_d[0], 32'hDEAD_BEEF);
    check("t4_lo_err", {31'b0, obs_e[0]}, 32'h1);
    check("t4_lo_ill", {31'b0, obs_ill}, 32'h1);
    xfer(0, 1'b0, 32'h8000_1000, 4'h0, 32'h0);
    check("t4_hi_rdata", obs_d[0], 32'hDEAD_BEEF);
    check("t4_hi_ill", {31'b0, obs_ill}, 32'h1);
    step(g);
    check("t4_ill_drop", {31'b0, obs_ill}, 32'h0);
    // write attempt on the read-only port leaves memory alone
    prior = mem_m[4];
    xfer(1, 1'b1, BASE + 32'h10, 4'hF, ~prior);
    check("t5_err", {31'b0, obs_e[1]}, 32'h1);
    xfer(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
    check("t5_rdata", obs_d[0], prior);
    // partial byte enables and an empty write
    xfer(0, 1'b1, BASE + 32'h20, 4'hF, 32'h1111_1111);
    xfer(0, 1'b1, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
    xfer(1, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
    check("t6_rdata", obs_d[1], 32'h11BB_11DD);
    xfer(0, 1'b1, BASE + 32'h20, 4'h0, 32'hFFFF_FFFF);
    check("t6_be0_err", {31'b0, obs_e[0]}, 32'h0);
    xfer(1, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
    check("t6_be0_rdata", obs_d[1], 32'h11BB_11DD);
    // reset mid-stream restores the bank pointer to port 0
    xfer(0, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
    req = 2'b11; we = 2'b00; addr[0] = BASE + 32'h20; addr[1] = BASE + 32'h28;
    rst = 1'b1;
    step(g);
    check("t6_rst_rvalid", {30'b0, obs_v}, 32'h0);
    rst = 1'b0;
    step(g);
    check("t6_rr_reset", {30'b0, g}, 32'h1);
    step(g);
    // random traffic from both ports
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) if (!req[p] && $urandom_range(0, 9) < 7) begin
        r = $urandom_range(0, 19);
        req[p] = 1'b1;
        we[p] = 1'($urandom_range(0, 1));
        be[p] = 4'($urandom());
        wdata[p] = $urandom();
        addr[p] = r == 0 ? BASE - 32'(4 * $urandom_range(1, 4)) :
                  r == 1 ? BASE + 32'd4096 + 32'(4 * $urandom_range(0, 4)) :
                  BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      end
      step(g);
    end
    req = 2'b00;
    step(g);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
